// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: a valid/ready request carrying op and
// operands, and a valid/ready response carrying results and flags.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             cf;
    logic             zf;
    logic             nf;
    logic             vf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, cf, zf, nf, vf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, cf, zf, nf, vf
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add multiplier, with registered result, high product half and flags.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADC = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 cf_q, cf_d;
    logic                 zf_q, zf_d;
    logic                 nf_q, nf_d;
    logic                 vf_q, vf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic                 carry_in_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       diff_s;
    logic [WIDTH:0]       shl_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic                 alu_cf_s;
    logic                 alu_vf_s;

    // ADC/SBB fold in the carry left by the previous completed op.
    assign carry_in_s = ((bus.op == OP_ADC) || (bus.op == OP_SBB)) ? cf_q : 1'b0;
    assign sum_s      = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, carry_in_s};
    assign diff_s     = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, carry_in_s};
    // Bit WIDTH of the widened shift is the last bit pushed out of the word.
    assign shl_s      = {1'b0, bus.a} << bus.b[CW-1:0];

    // Multiplier keeps {partial product high half, remaining multiplier bits}.
    assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};

    // Single-cycle datapath result and carry/overflow for the presented op.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_cf_s  = cf_q;
        alu_vf_s  = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADC: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_cf_s  = sum_s[WIDTH];
                alu_vf_s  = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
                         && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                alu_res_s = diff_s[WIDTH-1:0];
                alu_cf_s  = diff_s[WIDTH];
                alu_vf_s  = (bus.a[WIDTH-1] != bus.b[WIDTH-1])
                         && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res_s = bus.a & bus.b;
            OP_OR:  alu_res_s = bus.a | bus.b;
            OP_XOR: alu_res_s = bus.a ^ bus.b;
            OP_NOT: alu_res_s = ~bus.a;
            OP_SHL: begin
                alu_res_s = shl_s[WIDTH-1:0];
                alu_cf_s  = shl_s[WIDTH];
            end
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_cf_s  = cf_q;
            end
        endcase
    end

    // Control FSM: next state, multiplier stepping and result/flag capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        cf_d        = cf_q;
        zf_d        = zf_q;
        nf_d        = nf_q;
        vf_d        = vf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == OP_MUL) begin
                        state_d = ST_MUL;
                        cnt_d   = {CW{1'b0}};
                        mcand_d = bus.a;
                        acc_d   = {{WIDTH{1'b0}}, bus.b};
                    end else begin
                        state_d     = ST_DONE;
                        result_d    = alu_res_s;
                        result_hi_d = {WIDTH{1'b0}};
                        cf_d        = alu_cf_s;
                        zf_d        = (alu_res_s == {WIDTH{1'b0}});
                        nf_d        = alu_res_s[WIDTH-1];
                        vf_d        = alu_vf_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d = mul_next_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    result_d    = mul_next_s[WIDTH-1:0];
                    result_hi_d = mul_next_s[2*WIDTH-1:WIDTH];
                    cf_d        = (mul_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                    zf_d        = (mul_next_s == {(2*WIDTH){1'b0}});
                    nf_d        = mul_next_s[2*WIDTH-1];
                    vf_d        = 1'b0;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            mcand_q     <= {WIDTH{1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            result_q    <= {WIDTH{1'b0}};
            result_hi_q <= {WIDTH{1'b0}};
            cf_q        <= 1'b0;
            zf_q        <= 1'b0;
            nf_q        <= 1'b0;
            vf_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            cf_q        <= cf_d;
            zf_q        <= zf_d;
            nf_q        <= nf_d;
            vf_q        <= vf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.cf        = cf_q;
    assign bus.zf        = zf_q;
    assign bus.nf        = nf_q;
    assign bus.vf        = vf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (WIDTH=32) against a plain
// arithmetic reference model, plus directed handshake and reset scenarios.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic m_cf;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic cin_prev, output logic [31:0] res, output logic [31:0] hi,
                                      output logic cf, output logic zf, output logic nf, output logic vf);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned wide;
        longint          sa;
        longint          sb;
        longint          s;
        logic [63:0]     p;
        logic            c;
        int              sh;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        c  = (op == 4'd1 || op == 4'd3) ? cin_prev : 1'b0;
        res = 32'd0;
        hi  = 32'd0;
        cf  = cin_prev;
        vf  = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                wide = ua + ub + c;
                res  = wide[31:0];
                cf   = (wide > 64'hFFFF_FFFF);
                s    = sa + sb + c;
                vf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2, 4'd3: begin
                res = a - b - c;
                cf  = (ua < ub + c);
                s   = sa - sb - c;
                vf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: res = a & b;
            4'd5: res = a | b;
            4'd6: res = a ^ b;
            4'd7: res = ~a;
            4'd8: begin
                p   = ua * ub;
                res = p[31:0];
                hi  = p[63:32];
                cf  = (hi != 32'd0);
            end
            4'd9: begin
                sh  = int'(b[4:0]);
                res = a << sh;
                cf  = (sh == 0) ? 1'b0 : a[32-sh];
            end
            default: begin
                res = 32'd0;
                hi  = 32'd0;
            end
        endcase
        zf = (res == 32'd0) && (hi == 32'd0);
        nf = (op == 4'd8) ? hi[31] : res[31];
    endfunction

    // Issue one request at a negedge, track latency, check outputs, apply hold cycles of backpressure.
    task automatic run_op(input logic [3:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v, input int hold);
        logic [31:0] e_res;
        logic [31:0] e_hi;
        logic        e_cf, e_zf, e_nf, e_vf;
        int          lat;
        bit          busy_ok;
        ref_model(op_v, a_v, b_v, m_cf, e_res, e_hi, e_cf, e_zf, e_nf, e_vf);
        check("in_ready_before", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.op        = op_v;
        bus.a         = a_v;
        bus.b         = b_v;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.op       = 4'($urandom);
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check("latency", 64'(lat), (op_v == 4'd8) ? 64'd33 : 64'd1);
        check("busy_in_ready_low", 64'(busy_ok), 64'd1);
        check("result", 64'(bus.result), 64'(e_res));
        check("result_hi", 64'(bus.result_hi), 64'(e_hi));
        check("flags_czvn", 64'({bus.cf, bus.zf, bus.vf, bus.nf}), 64'({e_cf, e_zf, e_vf, e_nf}));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_results", {bus.result, bus.result_hi}, {e_res, e_hi});
            check("hold_flags", 64'({bus.cf, bus.zf, bus.vf, bus.nf}), 64'({e_cf, e_zf, e_vf, e_nf}));
            check("hold_handshake", 64'({bus.out_valid, bus.in_ready}), 64'b10);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_handshake", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        m_cf = e_cf;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit quiet;
        n_checks      = 0;
        n_pass        = 0;
        m_cf          = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_results", {bus.result, bus.result_hi}, 64'd0);
        check("rst_flags", 64'({bus.cf, bus.zf, bus.nf, bus.vf}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        run_op(4'd0, 32'd456, 32'd234, 0);
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd1, 32'd5, 32'd6, 0);
        run_op(4'd2, 32'd245, 32'd678, 0);
        run_op(4'd3, 32'd10, 32'd3, 0);
        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 5);
        run_op(4'd8, 32'hFFFF_FFFF, 32'd2, 2);
        run_op(4'd9, 32'h8000_0001, 32'd0, 0);
        run_op(4'd9, 32'h8000_0001, 32'd1, 0);
        run_op(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        run_op(4'd10, 32'h1234_5678, 32'd1, 1);
        run_op(4'd8, 32'd0, 32'hFFFF_FFFF, 0);

        for (int n = 0; n < 60; n++) begin
            run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), $urandom_range(0, 3));
        end

        // Reset in the middle of a multiply must discard it and clear cf.
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0);
        bus.in_valid = 1'b1;
        bus.op       = 4'd8;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'h1234_5678;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_results", {bus.result, bus.result_hi}, 64'd0);
        check("async_rst_flags", 64'({bus.cf, bus.zf, bus.nf, bus.vf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cf  = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) quiet = 1'b0;
        end
        check("no_valid_after_rst", 64'(quiet), 64'd1);
        run_op(4'd1, 32'd1, 32'd1, 0);
        run_op(4'd0, 32'd1, 32'd1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock, no other clock or reset domains.
REQ-004 in_valid  input  1  request present on op/A/B.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  4  operation code (REQ-010).
REQ-007 A, B  input  WIDTH each  operands.
REQ-008 out_valid  output  1  result/flags valid; out_ready  input  1  consumer accepts result.
REQ-009 result  output  WIDTH  low result; result_hi  output  WIDTH  high product half (0 for non-MUL); cf, zf, nf, vf  output  1 each  registered carry/borrow, zero, negative, signed-overflow flags.

Function
REQ-010 Op codes: 0000 ADD A+B; 0001 ADC A+B+cf; 0010 SUB A-B; 0011 SBB A-B-cf; 0100 AND; 0101 OR; 0110 XOR; 0111 NOT A; 1000 MUL unsigned A*B (2*WIDTH bits); 1001 SHL A << B[log2(WIDTH)-1:0]; 1010-1111 illegal.
REQ-011 Request accepted on a rising edge with in_valid=1 and in_ready=1; op, A, B, and current cf captured at that edge.
REQ-012 FSM states IDLE, MUL, DONE; in_ready=1 only in IDLE.
REQ-013 IDLE: accept of any non-MUL op -> DONE next edge with result/flags registered; out_valid=1 the cycle after accept (latency 1).
REQ-014 IDLE: accept of MUL -> MUL; iterative shift-add, one bit per cycle, counter 0..WIDTH-1; after WIDTH cycles in MUL -> DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-015 DONE: out_valid=1; result, result_hi and flags held stable until out_valid&&out_ready edge, then -> IDLE; no accept in same cycle (max throughput one op per 2 cycles).
REQ-016 Arithmetic ops computed at WIDTH+1 bits; cf = carry-out for ADD/ADC, borrow (1 when A < B+cin, unsigned) for SUB/SBB.
REQ-017 vf = signed overflow for ADD/ADC/SUB/SBB; vf=0 for all other ops.
REQ-018 zf = (result==0 and result_hi==0); nf = MSB of result (MUL: MSB of result_hi); updated by every legal op.
REQ-019 cf unchanged by AND/OR/XOR/NOT; MUL sets cf=(result_hi!=0); SHL sets cf = last bit shifted out (0 for shift 0).
REQ-020 Flags update on the edge entering DONE; cf feeding ADC/SBB is the value from the previous completed op.
REQ-021 Illegal op: result=0, result_hi=0, zf=1, nf=0, vf=0, cf unchanged; normal 1-cycle handshake.
REQ-022 Request inputs ignored outside IDLE; changes of A/B/op during MUL do not affect the product.

Reset
REQ-023 rst_n low: immediately (asynchronous) state=IDLE, out_valid=0, result=0, result_hi=0, cf=zf=nf=vf=0, MUL counter/accumulator=0; in_ready=1 from first cycle after deassertion.
REQ-024 Reset asserted mid-MUL or in DONE discards operation; no out_valid afterwards for it.

Verification
REQ-025 WIDTH=32, ADD A=456 B=234 -> 1 cycle later out_valid, result=690, cf=0, zf=0, vf=0.
REQ-026 ADD 0xFFFFFFFF+1 -> result=0, cf=1, zf=1; then ADC A=5 B=6 -> result=12, cf=0.
REQ-027 SUB A=245 B=678 -> result=0xFFFFFE4F, cf=1, nf=1, vf=0; ADD 0x7FFFFFFF+1 -> result=0x80000000, vf=1, nf=1.
REQ-028 MUL A=0xFFFFFFFF B=2 -> out_valid 33 cycles after accept, result_hi=1, result=0xFFFFFFFE, cf=1; in_ready=0 throughout.
REQ-029 Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0; out_ready=1 -> next cycle out_valid=0, in_ready=1.
REQ-030 rst_n pulsed low at MUL cycle 10 -> all outputs zero at once, out_valid never asserted for that MUL; next ADD 1+1 -> result=2, cf=0 (pre-reset cf discarded).
